cu_cmd_arbiter: RTL and testbench

//  Consumes the four CU command streams (read, prefetch_read, prefetch_write, write)
//  and serialises them onto the single PSL command port.

---
 rtl/cu_cmd_arbiter_pkg.sv | 31 +++
 rtl/cu_cmd_arbiter_rr_arbiter.sv | 37 +++
 rtl/cu_cmd_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cu_cmd_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_cmd_arbiter_pkg.sv
// Shared types and constants for the CU command arbiter.
// Holds the arbiter state enum, the command source indices and the credit
// clipping helper used when PSL command room is loaded.
package cu_cmd_arbiter_pkg;

    // Arbiter operating state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } cmd_arb_state_t;

    // Command source indices (slice position on src_* ports)
    localparam int unsigned CMD_SRC_READ    = 0;
    localparam int unsigned CMD_SRC_PREF_RD = 1;
    localparam int unsigned CMD_SRC_PREF_WR = 2;
    localparam int unsigned CMD_SRC_WRITE   = 3;
    localparam int unsigned CMD_SRC_NUM     = CMD_SRC_WRITE + 1;

    // Width of the credit / outstanding counters and of croom
    localparam int unsigned CNT_W = 8;

    // Clip a PSL room value to the credit saturation limit
    function automatic logic [CNT_W-1:0] credit_clip(
        input logic [CNT_W-1:0] room,
        input logic [CNT_W-1:0] limit
    );
        return (room > limit) ? limit : room;
    endfunction

endpackage

// File: rtl/cu_cmd_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer, wrapping modulo NUM_REQ. Pure combinational.
// Ports:
//   req_i        request vector
//   ptr_i        highest-priority index this cycle
//   gnt_c_o      one-hot grant (zero when no request)
//   gnt_idx_c_o  index of the granted request (zero when none)
//   gnt_any_c_o  any request granted
module cu_cmd_arbiter_rr_arbiter #(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [IDX_W-1:0]   gnt_idx_c_o,
    output logic               gnt_any_c_o
);

    // Scan from the pointer; first hit wins
    always_comb begin
        int unsigned idx;
        gnt_c_o     = '0;
        gnt_idx_c_o = '0;
        gnt_any_c_o = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_i) + k) % NUM_REQ;
            if (!gnt_any_c_o && req_i[IDX_W'(idx)]) begin
                gnt_c_o[IDX_W'(idx)] = 1'b1;
                gnt_idx_c_o          = IDX_W'(idx);
                gnt_any_c_o          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cu_cmd_arbiter.sv
// CU command arbiter: serialises the four CU command streams onto the single
// PSL command port with round-robin arbitration, gated by PSL credits.
// Every issued command carries a tag; each PSL response returns one credit.
// Ports:
//   clock, rstn_in        clock, asynchronous active-low reset
//   enabled_in            AFU running; low stops granting and drains
//   croom_valid_in/croom_in  load PSL command room into the credit counter (IDLE only)
//   src_valid_in/src_cmd_in  per-source command present / payload (source i at slice i)
//   src_ready_out         one-hot grant, combinational; command consumed this cycle
//   cmd_valid_out, cmd_out, cmd_src_out, cmd_tag_out  registered issued command
//   rsp_valid_in          PSL response, returns one credit
//   credits_out, outstanding_out  available credits / issued minus responded
//   idle_out              arbiter is idle
//   error_out             sticky: response seen with nothing outstanding
module cu_cmd_arbiter
    import cu_cmd_arbiter_pkg::*;
#(
    parameter int unsigned  NUM_SRC     = CMD_SRC_NUM,
    parameter int unsigned  CMD_W       = 128,
    parameter int unsigned  TAG_W       = 8,
    parameter int unsigned  MAX_CREDITS = 64,
    localparam int unsigned SRC_W       = $clog2(NUM_SRC)
) (
    input  logic                     clock,
    input  logic                     rstn_in,
    input  logic                     enabled_in,
    input  logic                     croom_valid_in,
    input  logic [CNT_W-1:0]         croom_in,
    input  logic [NUM_SRC-1:0]       src_valid_in,
    input  logic [NUM_SRC*CMD_W-1:0] src_cmd_in,
    output logic [NUM_SRC-1:0]       src_ready_out,
    output logic                     cmd_valid_out,
    output logic [CMD_W-1:0]         cmd_out,
    output logic [SRC_W-1:0]         cmd_src_out,
    output logic [TAG_W-1:0]         cmd_tag_out,
    input  logic                     rsp_valid_in,
    output logic [CNT_W-1:0]         credits_out,
    output logic [CNT_W-1:0]         outstanding_out,
    output logic                     idle_out,
    output logic                     error_out
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CREDITS);

    cmd_arb_state_t   state_q, state_d;
    logic [CNT_W-1:0] credits_q, credits_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;
    logic             idle_q;

    logic             cmd_valid_q;
    logic [CMD_W-1:0] cmd_q;
    logic [SRC_W-1:0] cmd_src_q;
    logic [TAG_W-1:0] cmd_tag_q;

    logic               grant_en_c;
    logic [NUM_SRC-1:0] req_c;
    logic [NUM_SRC-1:0] gnt_c;
    logic [SRC_W-1:0]   gnt_idx_c;
    logic               gnt_any_c;
    logic               rsp_ok_c;

    logic [CMD_W-1:0] src_cmd_a [NUM_SRC];

    // Unpack per-source payload slices
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slice
        assign src_cmd_a[g] = src_cmd_in[g*CMD_W +: CMD_W];
    end

    // Grants only while running, enabled in this very cycle, and holding a credit
    assign grant_en_c = (state_q == RUN) && enabled_in && (credits_q != '0);
    assign req_c      = src_valid_in & {NUM_SRC{grant_en_c}};

    // A response with nothing outstanding is flagged and otherwise ignored
    assign rsp_ok_c = rsp_valid_in && (outst_q != '0);

    cu_cmd_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_SRC)
    ) u_rr (
        .req_i       (req_c),
        .ptr_i       (ptr_q),
        .gnt_c_o     (gnt_c),
        .gnt_idx_c_o (gnt_idx_c),
        .gnt_any_c_o (gnt_any_c)
    );

    // Next state, counters, tag and pointer
    always_comb begin
        state_d   = state_q;
        credits_d = credits_q;
        outst_d   = outst_q;
        tag_d     = tag_q;
        ptr_d     = ptr_q;
        err_d     = err_q;

        case (state_q)
            IDLE:    if (enabled_in && (credits_q != '0)) state_d = RUN;
            RUN:     if (!enabled_in) state_d = DRAIN;
            DRAIN: begin
                if (enabled_in)           state_d = RUN;
                else if (outst_q == '0)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Room is only taken from PSL while idle; grant and response cancel out
        if ((state_q == IDLE) && croom_valid_in) begin
            credits_d = credit_clip(croom_in, MAX_C);
        end else if (gnt_any_c && !rsp_ok_c) begin
            credits_d = credits_q - CNT_W'(1);
        end else if (rsp_ok_c && !gnt_any_c && (credits_q < MAX_C)) begin
            credits_d = credits_q + CNT_W'(1);
        end

        if (gnt_any_c && !rsp_ok_c) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (rsp_ok_c && !gnt_any_c) begin
            outst_d = outst_q - CNT_W'(1);
        end

        if (gnt_any_c) begin
            tag_d = tag_q + TAG_W'(1);
            ptr_d = (gnt_idx_c == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx_c + SRC_W'(1);
        end

        if (rsp_valid_in && (outst_q == '0)) begin
            err_d = 1'b1;
        end
    end

    // State, counters and the issued-command register
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q     <= IDLE;
            credits_q   <= '0;
            outst_q     <= '0;
            tag_q       <= '0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            idle_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            cmd_src_q   <= '0;
            cmd_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            credits_q   <= credits_d;
            outst_q     <= outst_d;
            tag_q       <= tag_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            // Tracks the state register but reads 0 while in reset
            idle_q      <= (state_d == IDLE);
            cmd_valid_q <= gnt_any_c;
            if (gnt_any_c) begin
                cmd_q     <= src_cmd_a[gnt_idx_c];
                cmd_src_q <= gnt_idx_c;
                cmd_tag_q <= tag_q;
            end
        end
    end

    assign src_ready_out   = gnt_c;
    assign cmd_valid_out   = cmd_valid_q;
    assign cmd_out         = cmd_q;
    assign cmd_src_out     = cmd_src_q;
    assign cmd_tag_out     = cmd_tag_q;
    assign credits_out     = credits_q;
    assign outstanding_out = outst_q;
    assign idle_out        = idle_q;
    assign error_out       = err_q;

endmodule

// File: tb/tb_cu_cmd_arbiter.sv
// Bench for cu_cmd_arbiter: directed stimulus, a cycle-level reference model
// compared every cycle, plus hand-computed expectations at key points.
module tb_cu_cmd_arbiter;

    localparam int NS = 4;
    localparam int CW = 128;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic            clock;
    logic            rstn_in;
    logic            enabled_in;
    logic            croom_valid_in;
    logic [7:0]      croom_in;
    logic [NS-1:0]   src_valid_in;
    logic [NS*CW-1:0] src_cmd_in;
    logic [NS-1:0]   src_ready_out;
    logic            cmd_valid_out;
    logic [CW-1:0]   cmd_out;
    logic [1:0]      cmd_src_out;
    logic [7:0]      cmd_tag_out;
    logic            rsp_valid_in;
    logic [7:0]      credits_out;
    logic [7:0]      outstanding_out;
    logic            idle_out;
    logic            error_out;

    int checks;
    int errors;

    // Reference model state
    int         m_mode, m_nm, m_credits, m_out, m_next_tag, m_ptr, m_g;
    int         m_src, m_ctag;
    bit         m_cmd_valid, m_idle, m_err, m_rok;
    logic [CW-1:0] m_cmd;

    cu_cmd_arbiter #(
        .NUM_SRC     (NS),
        .CMD_W       (CW),
        .TAG_W       (8),
        .MAX_CREDITS (64)
    ) dut (
        .clock           (clock),
        .rstn_in         (rstn_in),
        .enabled_in      (enabled_in),
        .croom_valid_in  (croom_valid_in),
        .croom_in        (croom_in),
        .src_valid_in    (src_valid_in),
        .src_cmd_in      (src_cmd_in),
        .src_ready_out   (src_ready_out),
        .cmd_valid_out   (cmd_valid_out),
        .cmd_out         (cmd_out),
        .cmd_src_out     (cmd_src_out),
        .cmd_tag_out     (cmd_tag_out),
        .rsp_valid_in    (rsp_valid_in),
        .credits_out     (credits_out),
        .outstanding_out (outstanding_out),
        .idle_out        (idle_out),
        .error_out       (error_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_payload(input int seed);
        logic [CW-1:0] p;
        src_cmd_in = '0;
        for (int i = 0; i < NS; i++) begin
            p = {32'(seed), 32'(i), 32'hA5A5_0000, 32'(seed * 7 + i)};
            src_cmd_in = src_cmd_in | ((NS*CW)'(p) << (i * CW));
        end
    endtask

    // Source the model would grant now: first valid at/after pointer, or -1
    function automatic int m_pick();
        if (m_mode != M_RUN || !enabled_in || m_credits == 0) return -1;
        for (int k = 0; k < NS; k++) begin
            if (((src_valid_in >> ((m_ptr + k) % NS)) & 4'b0001) != 4'b0000)
                return (m_ptr + k) % NS;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] exp_ready();
        int g;
        g = m_pick();
        return (g >= 0) ? (4'b0001 << g) : 4'b0000;
    endfunction

    // Reference model: advance one cycle from the inputs seen at the edge
    initial forever begin
        @(posedge clock or negedge rstn_in);
        if (!rstn_in) begin
            m_mode = M_IDLE; m_credits = 0; m_out = 0; m_next_tag = 0; m_ptr = 0;
            m_cmd_valid = 0; m_idle = 0; m_err = 0; m_src = 0; m_ctag = 0; m_cmd = '0;
        end else begin
            m_g   = m_pick();
            m_rok = rsp_valid_in && (m_out > 0);
            if (rsp_valid_in && m_out == 0) m_err = 1;
            m_nm = m_mode;
            if (m_mode == M_IDLE && enabled_in && m_credits > 0) m_nm = M_RUN;
            if (m_mode == M_RUN && !enabled_in) m_nm = M_DRAIN;
            if (m_mode == M_DRAIN) m_nm = enabled_in ? M_RUN : ((m_out == 0) ? M_IDLE : M_DRAIN);
            if (m_mode == M_IDLE && croom_valid_in) begin
                m_credits = (int'(croom_in) < 64) ? int'(croom_in) : 64;
            end else begin
                m_credits = m_credits - ((m_g >= 0) ? 1 : 0) + (m_rok ? 1 : 0);
                if (m_credits > 64) m_credits = 64;
            end
            m_out = m_out + ((m_g >= 0) ? 1 : 0) - (m_rok ? 1 : 0);
            m_cmd_valid = (m_g >= 0);
            if (m_g >= 0) begin
                m_cmd      = CW'(src_cmd_in >> (m_g * CW));
                m_src      = m_g;
                m_ctag     = m_next_tag;
                m_next_tag = (m_next_tag + 1) % 256;
                m_ptr      = (m_g + 1) % NS;
            end
            m_mode = m_nm;
            m_idle = (m_nm == M_IDLE);
        end
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clock);
        if (rstn_in) begin
            chk("ready", 128'(src_ready_out), 128'(exp_ready()));
            chk("cmd_valid", 128'(cmd_valid_out), 128'(m_cmd_valid));
            if (m_cmd_valid) begin
                chk("cmd", cmd_out, m_cmd);
                chk("cmd_src", 128'(cmd_src_out), 128'(m_src));
                chk("cmd_tag", 128'(cmd_tag_out), 128'(m_ctag));
            end
            chk("credits", 128'(credits_out), 128'(m_credits));
            chk("outstanding", 128'(outstanding_out), 128'(m_out));
            chk("idle", 128'(idle_out), 128'(m_idle));
            chk("error", 128'(error_out), 128'(m_err));
        end
    end

    task automatic do_reset();
        enabled_in = 0; croom_valid_in = 0; croom_in = 0; src_valid_in = 0; rsp_valid_in = 0;
        rstn_in = 0;
        cyc();
        rstn_in = 1;
    endtask

    initial begin
        int prev_tag;
        int wraps;
        checks = 0; errors = 0;
        rstn_in = 0; enabled_in = 0; croom_valid_in = 0; croom_in = 0;
        src_valid_in = 0; rsp_valid_in = 0;
        set_payload(1);
        cyc(); cyc();
        chk("rst_credits", 128'(credits_out), 128'(0));
        chk("rst_outstanding", 128'(outstanding_out), 128'(0));
        chk("rst_idle", 128'(idle_out), 128'(0));
        chk("rst_cmd_valid", 128'(cmd_valid_out), 128'(0));
        chk("rst_error", 128'(error_out), 128'(0));
        chk("rst_ready", 128'(src_ready_out), 128'(0));
        rstn_in = 1;

        // 1: croom 4, all sources valid -> 0,1,2,3 then stall
        croom_valid_in = 1; croom_in = 8'd4;
        cyc();
        chk("t1_load", 128'(credits_out), 128'(4));
        chk("t1_idle", 128'(idle_out), 128'(1));
        croom_valid_in = 0; enabled_in = 1; src_valid_in = 4'b1111;
        cyc();
        chk("t1_first_ready", 128'(src_ready_out), 128'(4'b0001));
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k <= 4) begin
                chk("t1_valid", 128'(cmd_valid_out), 128'(1));
                chk("t1_src", 128'(cmd_src_out), 128'(k - 1));
                chk("t1_tag", 128'(cmd_tag_out), 128'(k - 1));
            end else begin
                chk("t1_stall", 128'(cmd_valid_out), 128'(0));
            end
        end
        chk("t1_credits", 128'(credits_out), 128'(0));
        chk("t1_outstanding", 128'(outstanding_out), 128'(4));
        chk("t1_ready_zero", 128'(src_ready_out), 128'(0));

        // 2: credits 2, only source 2, response every cycle after first issue
        do_reset();
        croom_valid_in = 1; croom_in = 8'd2;
        cyc();
        croom_valid_in = 0; enabled_in = 1; src_valid_in = 4'b0100;
        cyc();
        cyc();
        chk("t2_credits0", 128'(credits_out), 128'(1));
        chk("t2_src0", 128'(cmd_src_out), 128'(2));
        rsp_valid_in = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t2_credits", 128'(credits_out), 128'(1));
            chk("t2_outstanding", 128'(outstanding_out), 128'(1));
            chk("t2_valid", 128'(cmd_valid_out), 128'(1));
            chk("t2_tag", 128'(cmd_tag_out), 128'(i + 1));
        end
        rsp_valid_in = 0; src_valid_in = 0;
        cyc();

        // 3: tag wrap over 300 back-to-back grants with responses
        set_payload(2);
        src_valid_in = 4'b0100; rsp_valid_in = 1;
        prev_tag = -1; wraps = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (prev_tag == 255) begin
                chk("t3_wrap", 128'(cmd_tag_out), 128'(0));
                wraps++;
            end
            prev_tag = int'(cmd_tag_out);
        end
        chk("t3_wraps_seen", 128'(wraps), 128'(1));
        chk("t3_last_tag", 128'(cmd_tag_out), 128'(50));
        chk("t3_no_error", 128'(error_out), 128'(0));
        src_valid_in = 0;
        cyc();
        rsp_valid_in = 0;
        chk("t3_outstanding", 128'(outstanding_out), 128'(0));
        chk("t3_credits", 128'(credits_out), 128'(2));

        // 4: drop enable with 3 outstanding, drain to idle
        do_reset();
        croom_valid_in = 1; croom_in = 8'd4;
        cyc();
        croom_valid_in = 0; enabled_in = 1; src_valid_in = 4'b1111;
        cyc();
        cyc(); cyc(); cyc();
        chk("t4_outstanding3", 128'(outstanding_out), 128'(3));
        enabled_in = 0;
        #1;
        chk("t4_ready_off", 128'(src_ready_out), 128'(0));
        cyc();
        chk("t4_no_issue", 128'(cmd_valid_out), 128'(0));
        chk("t4_draining", 128'(idle_out), 128'(0));
        rsp_valid_in = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_drain_cnt", 128'(outstanding_out), 128'(2 - i));
        end
        chk("t4_not_idle_yet", 128'(idle_out), 128'(0));
        rsp_valid_in = 0;
        cyc();
        chk("t4_idle", 128'(idle_out), 128'(1));
        chk("t4_credits", 128'(credits_out), 128'(4));

        // 5: response with nothing outstanding
        rsp_valid_in = 1;
        cyc();
        rsp_valid_in = 0;
        chk("t5_error", 128'(error_out), 128'(1));
        chk("t5_credits", 128'(credits_out), 128'(4));
        chk("t5_outstanding", 128'(outstanding_out), 128'(0));
        cyc(); cyc();
        chk("t5_sticky", 128'(error_out), 128'(1));

        // 6: croom saturation, then async reset mid-run
        croom_valid_in = 1; croom_in = 8'd200;
        cyc();
        croom_valid_in = 0;
        chk("t6_sat", 128'(credits_out), 128'(64));
        enabled_in = 1; src_valid_in = 4'b1111;
        cyc(); cyc(); cyc();
        #2;
        rstn_in = 0;
        #1;
        chk("t6_credits", 128'(credits_out), 128'(0));
        chk("t6_outstanding", 128'(outstanding_out), 128'(0));
        chk("t6_cmd_valid", 128'(cmd_valid_out), 128'(0));
        chk("t6_cmd", cmd_out, 128'(0));
        chk("t6_tag", 128'(cmd_tag_out), 128'(0));
        chk("t6_src", 128'(cmd_src_out), 128'(0));
        chk("t6_error", 128'(error_out), 128'(0));
        chk("t6_idle", 128'(idle_out), 128'(0));
        chk("t6_ready", 128'(src_ready_out), 128'(0));
        enabled_in = 0; src_valid_in = 0;
        cyc();
        rstn_in = 1;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
